// File: rtl/dual_clock_fifo.sv
// Asynchronous dual-clock FIFO with Gray-coded pointers and 2-flop synchronizers.
// First-word-fall-through read port: rdata shows the head word whenever rempty is low.
module dual_clock_fifo #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 2,
  parameter int ALMOST_GAP = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 wfull,
  output logic                 almost_full,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rempty,
  output logic                 almost_empty
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int PW    = ADDR_SIZE + 1;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - ALMOST_GAP);
  localparam logic [PW-1:0] AE_LEVEL  = PW'(ALMOST_GAP);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [PW-1:0] wbin_reg, wgray_reg, wbin_next, wgray_next;
  logic [PW-1:0] wq1_rgray_reg, wq2_rgray_reg, wq2_rbin;
  logic [PW-1:0] wdiff;
  logic          wfull_reg, almost_full_reg, wfull_next, almost_full_next;
  logic          wen;

  logic [PW-1:0] rbin_reg, rgray_reg, rbin_next, rgray_next;
  logic [PW-1:0] rq1_wgray_reg, rq2_wgray_reg, rq2_wbin;
  logic [PW-1:0] rdiff;
  logic          rempty_reg, almost_empty_reg, rempty_next, almost_empty_next;
  logic          ren;

  // Gray-to-binary of the synchronized pointers: bit i is the XOR of bits [MSB:i].
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign wq2_rbin[gi] = ^wq2_rgray_reg[PW-1:gi];
      assign rq2_wbin[gi] = ^rq2_wgray_reg[PW-1:gi];
    end
  endgenerate

  // Write domain
  assign wen              = winc & ~wfull_reg;
  assign wbin_next        = wbin_reg + PW'(wen);
  assign wgray_next       = wbin_next ^ (wbin_next >> 1);
  assign wfull_next       = (wgray_next == (wq2_rgray_reg ^ FULL_MASK));
  assign wdiff            = wbin_next - wq2_rbin;
  assign almost_full_next = (wdiff >= AF_LEVEL);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wbin_reg        <= '0;
      wgray_reg       <= '0;
      wq1_rgray_reg   <= '0;
      wq2_rgray_reg   <= '0;
      wfull_reg       <= 1'b0;
      almost_full_reg <= 1'b0;
    end else begin
      wbin_reg        <= wbin_next;
      wgray_reg       <= wgray_next;
      wq1_rgray_reg   <= rgray_reg;
      wq2_rgray_reg   <= wq1_rgray_reg;
      wfull_reg       <= wfull_next;
      almost_full_reg <= almost_full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[wbin_reg[ADDR_SIZE-1:0]] <= wdata;
    end
  end

  // Read domain
  assign ren               = rinc & ~rempty_reg;
  assign rbin_next         = rbin_reg + PW'(ren);
  assign rgray_next        = rbin_next ^ (rbin_next >> 1);
  assign rempty_next       = (rgray_next == rq2_wgray_reg);
  assign rdiff             = rq2_wbin - rbin_next;
  assign almost_empty_next = (rdiff <= AE_LEVEL);

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_reg         <= '0;
      rgray_reg        <= '0;
      rq1_wgray_reg    <= '0;
      rq2_wgray_reg    <= '0;
      rempty_reg       <= 1'b1;
      almost_empty_reg <= 1'b1;
    end else begin
      rbin_reg         <= rbin_next;
      rgray_reg        <= rgray_next;
      rq1_wgray_reg    <= wgray_reg;
      rq2_wgray_reg    <= rq1_wgray_reg;
      rempty_reg       <= rempty_next;
      almost_empty_reg <= almost_empty_next;
    end
  end

  assign rdata        = mem[rbin_reg[ADDR_SIZE-1:0]];
  assign wfull        = wfull_reg;
  assign almost_full  = almost_full_reg;
  assign rempty       = rempty_reg;
  assign almost_empty = almost_empty_reg;

endmodule

// File: tb/tb_dual_clock_fifo.sv
// Directed self-checking bench for dual_clock_fifo: flags, FWFT data, wrap and clock ratios.
`timescale 1ns/1ps
module tb_dual_clock_fifo;

  localparam int DEPTH = 4;

  logic        clk, rclk, resetn, rrst_n;
  logic        winc, rinc;
  logic [31:0] wdata, rdata;
  logic        wfull, almost_full, rempty, almost_empty;

  real clk_half  = 23.256;
  real rclk_half = 6.734;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  dual_clock_fifo #(.DATA_SIZE(32), .ADDR_SIZE(2), .ALMOST_GAP(1)) dut (
    .clk(clk), .resetn(resetn), .rclk(rclk), .rrst_n(rrst_n),
    .winc(winc), .wdata(wdata), .wfull(wfull), .almost_full(almost_full),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .almost_empty(almost_empty)
  );

  initial begin
    clk = 0;
    forever #(clk_half) clk = ~clk;
  end
  initial begin
    rclk = 0;
    forever #(rclk_half) rclk = ~rclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input logic got, input logic want, input string name);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    @(negedge clk);
    winc  = 1'b1;
    wdata = d;
    @(posedge clk);
    #1;
    winc = 1'b0;
  endtask

  task automatic pop_word(input logic [31:0] exp, input string name);
    @(negedge rclk);
    check_bit(rempty, 1'b0, {name, " rempty"});
    n_checks++;
    if (rdata !== exp) begin
      n_fail++;
      $display("FAIL %s rdata: got %h want %h", name, rdata, exp);
    end
    rinc = 1'b1;
    @(posedge rclk);
    #1;
    rinc = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(posedge rclk);
      #1;
      if (!rempty) break;
    end
    n_checks++;
    if (rempty !== 1'b0) begin
      n_fail++;
      $display("FAIL %s wait for data: rempty got %b want 0 after 20 rclk", name, rempty);
    end
    repeat (6) @(posedge rclk);
    #1;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    repeat (8) @(posedge rclk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    rrst_n = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    repeat (4) @(posedge clk);
    repeat (2) @(posedge rclk);
    @(negedge clk);
    resetn = 1'b1;
    rrst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    check_bit(rempty, 1'b1, "reset rempty");
    check_bit(almost_empty, 1'b1, "reset almost_empty");
    check_bit(wfull, 1'b0, "reset wfull");
    check_bit(almost_full, 1'b0, "reset almost_full");
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    int k;
    write_word(32'hAAAA5555);
    for (k = 1; k <= 10; k++) begin
      @(posedge rclk);
      #1;
      if (!rempty) break;
    end
    n_checks++;
    if (k > 3) begin
      n_fail++;
      $display("FAIL single rempty latency: got %0d rclk edges want <= 3", k);
    end
    pop_word(32'hAAAA5555, "single");
    check_bit(rempty, 1'b1, "single rempty after pop");
    $display("test_single_word done, latency %0d", k);
  endtask

  task automatic test_fill();
    settle();
    write_word(32'h1);
    check_bit(almost_full, 1'b0, "fill af after 1");
    write_word(32'h2);
    check_bit(almost_full, 1'b0, "fill af after 2");
    write_word(32'h3);
    check_bit(almost_full, 1'b1, "fill af after 3");
    check_bit(wfull, 1'b0, "fill wfull after 3");
    write_word(32'h4);
    check_bit(wfull, 1'b1, "fill wfull after 4");
    write_word(32'h5);
    check_bit(wfull, 1'b1, "fill wfull after ignored 5th");
    wait_ready("fill");
    for (int i = 1; i <= 4; i++) pop_word(32'(i), "fill");
    check_bit(rempty, 1'b1, "fill rempty after 4 pops");
    repeat (10) @(posedge rclk);
    #1;
    check_bit(rempty, 1'b1, "fill rempty stays (5th dropped)");
    $display("test_fill done");
  endtask

  task automatic test_thresholds();
    settle();
    write_word(32'h11);
    write_word(32'h22);
    wait_ready("thr");
    check_bit(almost_empty, 1'b0, "thr ae with 2 words");
    pop_word(32'h11, "thr first");
    check_bit(almost_empty, 1'b1, "thr ae with 1 word");
    check_bit(rempty, 1'b0, "thr rempty with 1 word");
    pop_word(32'h22, "thr last");
    check_bit(rempty, 1'b1, "thr rempty after last");
    check_bit(almost_empty, 1'b1, "thr ae when empty");
    @(negedge rclk);
    rinc = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
    rinc = 1'b0;
    check_bit(rempty, 1'b1, "thr rinc while empty");
    write_word(32'h33);
    wait_ready("thr after empty rinc");
    pop_word(32'h33, "thr after empty rinc");
    check_bit(rempty, 1'b1, "thr rempty final");
    $display("test_thresholds done");
  endtask

  task automatic stream_writer(input int n, input logic [31:0] base);
    int   cnt = 0;
    logic full_s;
    for (int cyc = 0; cyc < 3000 && cnt < n; cyc++) begin
      @(negedge clk);
      winc   = 1'b1;
      wdata  = base + 32'(cnt);
      full_s = wfull;
      @(posedge clk);
      if (!full_s) begin
        sb_q.push_back(wdata);
        cnt++;
        n_checks++;
        if (sb_q.size() > DEPTH) begin
          n_fail++;
          $display("FAIL stream occupancy: got %0d want <= %0d", sb_q.size(), DEPTH);
        end
      end
    end
    @(negedge clk);
    winc = 1'b0;
    n_checks++;
    if (cnt != n) begin
      n_fail++;
      $display("FAIL stream writer count: got %0d want %0d", cnt, n);
    end
  endtask

  task automatic stream_reader(input int n, input int rate);
    int          got = 0;
    logic        emp;
    logic [31:0] d, e;
    for (int cyc = 0; cyc < 6000 && got < n; cyc++) begin
      @(negedge rclk);
      rinc = ($urandom_range(99) < 32'(rate));
      emp  = rempty;
      d    = rdata;
      @(posedge rclk);
      if (rinc && !emp) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream read: got %h want no data (model empty)", d);
        end else begin
          e = sb_q.pop_front();
          if (d !== e) begin
            n_fail++;
            $display("FAIL stream data #%0d: got %h want %h", got, d, e);
          end
        end
        got++;
      end
    end
    @(negedge rclk);
    rinc = 1'b0;
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL stream reader count: got %0d want %0d", got, n);
    end
  endtask

  task automatic run_stream(input int n, input int rate, input logic [31:0] base, input string name);
    settle();
    sb_q.delete();
    fork
      stream_writer(n, base);
      stream_reader(n, rate);
    join
    settle();
    check_bit(rempty, 1'b1, {name, " rempty at end"});
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s leftover: got %0d want 0", name, sb_q.size());
    end
    $display("%s done: %0d words", name, n);
  endtask

  task automatic test_wrap();
    run_stream(20, 40, 32'h0000_0100, "test_wrap");
  endtask

  task automatic test_clock_ratio();
    clk_half  = 23.256;
    rclk_half = 7.752;
    run_stream(24, 100, 32'h0000_2000, "ratio rclk 3x faster");
    clk_half  = 23.256;
    rclk_half = 69.768;
    run_stream(24, 100, 32'h0000_3000, "ratio rclk 3x slower");
    clk_half  = 23.256;
    rclk_half = 6.734;
    settle();
  endtask

  task automatic test_reset_midop();
    write_word(32'hDEAD0001);
    write_word(32'hDEAD0002);
    write_word(32'hDEAD0003);
    apply_reset();
    check_bit(rempty, 1'b1, "midop rempty");
    check_bit(almost_empty, 1'b1, "midop almost_empty");
    check_bit(wfull, 1'b0, "midop wfull");
    check_bit(almost_full, 1'b0, "midop almost_full");
    write_word(32'hBEEF0000);
    wait_ready("midop");
    pop_word(32'hBEEF0000, "midop after reset");
    $display("test_reset_midop done");
  endtask

  initial begin
    resetn = 1'b0;
    rrst_n = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = '0;
    test_reset();
    test_single_word();
    test_fill();
    test_thresholds();
    test_wrap();
    test_clock_ratio();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
